// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module : fetch_unit_pkg
// Purpose: Shared definitions for the instruction-fetch stage.
//          - Global defines (include-guarded): INSTRMEM_SIZE, FETCH_RESET_PC,
//            NOP_INSTR (the bubble encoding decode inserts).
//          - Fetch-buffer entry layout and a PC alignment helper.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef FETCH_DEFINES_VH
`define FETCH_DEFINES_VH
`define INSTRMEM_SIZE  256
`define FETCH_RESET_PC 32'h0000_0000
`define NOP_INSTR      32'h0000_0013
`endif

package fetch_unit_pkg;

  // Width of one buffered {pc, instr} pair.
  localparam int unsigned FETCH_ENTRY_W = 64;

  // NOP encoding, exported for the decode stage.
  localparam logic [31:0] NOP_INSTR = `NOP_INSTR;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Purpose: Small synchronous FIFO between fetch and decode. A push into a
//          full FIFO is accepted when a pop happens in the same cycle.
//          Flush empties the FIFO (entries themselves are left untouched).
// Ports  : clk, reset (sync, active-low)
//          push, pop, flush  - control
//          din / dout        - WIDTH-bit entry in / head entry out
//          empty, full       - status
//          count             - number of valid entries (0..DEPTH)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_pop;
  logic             w_push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // When full, wr_ptr == rd_ptr: the incoming entry lands in the slot being
  // vacated by the simultaneous pop, which becomes the new tail.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop) & ~flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (w_push) begin
        mem_q[wr_ptr_q] <= din;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module : fetch_unit
// Purpose: Instruction-fetch stage. Owns the PC, addresses the instruction
//          memory (combinational read, zero latency), and buffers {pc, instr}
//          pairs toward decode with a valid/ready handshake. A redirect from
//          execute flushes the buffer and reloads the PC (word-aligned).
// Ports  : clk, reset (sync, active-low)
//          imem_addr  - word address to instruction memory (pc[ADDR_W+1:2])
//          imem_instr - instruction read at imem_addr, same cycle
//          redirect_valid / redirect_pc - branch/jump target from execute
//          out_valid / out_ready / out_instr / out_pc - decode handshake
//          fetch_count, stall_count - perf counters (FETCH_PERF_EN only)
// Config : define FETCH_PERF_EN to add the performance counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter  int          IMEM_SIZE  = `INSTRMEM_SIZE,
  parameter  logic [31:0] RESET_PC   = `FETCH_RESET_PC,
  parameter  int          FIFO_DEPTH = 2,
  localparam int          ADDR_W     = $clog2(IMEM_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      pc_q, pc_d;
  logic             w_pop;
  logic             w_push;
  logic             w_empty;
  logic             w_full;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_din;
  fetch_entry_t     w_dout;

  // Upper PC bits beyond the memory depth are dropped, so the address wraps
  // modulo IMEM_SIZE while the PC itself wraps modulo 2^32.
  assign imem_addr = pc_q[ADDR_W+1:2];

  assign out_valid = ~w_empty;
  assign out_instr = w_dout.instr;
  assign out_pc    = w_dout.pc;

  assign w_pop  = out_valid & out_ready;
  assign w_push = ~redirect_valid & ((w_count < CNT_W'(FIFO_DEPTH)) | w_pop);

  assign w_din = '{pc: pc_q, instr: imem_instr};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
    end else if (w_push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // A pop coinciding with a redirect is still accepted by decode; the flush
  // simply overrides its effect on the buffer state.
  fetch_fifo #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   (w_din),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .count (w_count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_q + 32'(w_pop);
      stall_count_q <= stall_count_q + 32'(w_full & ~w_pop);
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  logic w_unused_full;
  assign w_unused_full = w_full;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module : tb_fetch_unit
// Purpose: Self-checking bench for fetch_unit. The driver applies directed
//          then random stimulus and keeps a queue of the {pc, instr} pairs
//          the fetch buffer should hold; a monitor compares the DUT head
//          against that queue and retires entries on accepted handshakes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic [31:0] m_fc = 32'd0;
  logic [31:0] m_sc = 32'd0;
`endif

  logic [31:0] mem [256];
  assign imem_instr = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  int          vectors     = 0;
  int          miscompares = 0;
  bit          mon_en      = 1'b0;
  bit          mon_pop     = 1'b0;
  logic [63:0] exp_q [$];          // expected buffer contents, head first
  logic [31:0] m_pc = 32'd0;       // reference program counter

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the head against the scoreboard, retire on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_pop = 1'b0;
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        if (out_valid) begin
          chk("out_pc",    64'(out_pc),    64'(exp_q[0][63:32]));
          chk("out_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          mon_pop = 1'b1;
        end
      end
    end
  end

  // One clock of stimulus followed by the reference-model step for that edge.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    int cnt_before;
    @(posedge clk);
    #1;
    mon_en         = 1'b1;
    reset          = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    #1;
    chk("imem_addr", 64'(imem_addr), 64'(m_pc[9:2]));
`ifdef FETCH_PERF_EN
    chk("fetch_count", 64'(fetch_count), 64'(m_fc));
    chk("stall_count", 64'(stall_count), 64'(m_sc));
`endif
    cnt_before = exp_q.size() + int'(mon_pop);
`ifdef FETCH_PERF_EN
    if (!r) begin
      m_fc = 32'd0;
      m_sc = 32'd0;
    end else begin
      m_fc = m_fc + 32'(mon_pop);
      if (cnt_before == DEPTH && !mon_pop) m_sc = m_sc + 32'd1;
    end
`endif
    if (!r) begin
      exp_q.delete();
      m_pc = 32'd0;
    end else if (rv) begin
      exp_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else if (cnt_before < DEPTH || mon_pop) begin
      exp_q.push_back({m_pc, mem[m_pc[9:2]]});
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    out_ready      = 1'b1;

    // Reset: head entry reads as zero.
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("reset_out_pc",    64'(out_pc),    64'd0);
    chk("reset_out_instr", 64'(out_instr), 64'd0);

    // Release and stream.
    repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // Back-pressure: buffer fills, PC holds, head stable.
    repeat (5) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // Redirect to a misaligned target while full.
    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0043, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // Back-to-back redirects: last one wins.
    cycle(1'b1, 1'b1, 32'h0000_0020, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0080, 1'b1);
    repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // 32-bit PC wrap and memory address wrap.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (5) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // Reset with a full buffer and a competing redirect.
    repeat (3) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0000_0080, 1'b0);
    repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom % 64) != 0, ($urandom % 12) == 0, $urandom, ($urandom % 4) != 0);
    end
    repeat (4) cycle(1'b1, 1'b0, 32'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter, drives the word address into the instruction memory, and captures the returned instruction.
- Buffers {pc, instr} pairs in a small FIFO toward the decode stage using a valid/ready handshake.
- Supports a one-cycle redirect from execute (branch/jump) that flushes in-flight fetches.

Parameters:
- IMEM_SIZE, `INSTRMEM_SIZE (default 256): instruction memory depth in 32-bit words; ADDR_W = $clog2(IMEM_SIZE).
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- FIFO_DEPTH, 2: fetch-buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- imem_addr  output  ADDR_W  word address to instruction memory = pc[ADDR_W+1:2].
- imem_instr  input  32  instruction word from instruction memory (combinational read of imem_addr, same cycle).
- redirect_valid  input  1  take redirect_pc as the new PC this cycle.
- redirect_pc  input  32  redirect target byte address.
- out_valid  output  1  head FIFO entry is valid.
- out_ready  input  1  decode accepts the head entry this cycle.
- out_instr  output  32  instruction at FIFO head.
- out_pc  output  32  byte PC of out_instr.

Behaviour:
- Reset (reset==0 at a rising edge):
  - pc <= RESET_PC; FIFO count, read pointer and write pointer <= 0; all entries <= 0.
  - Therefore out_valid=0, out_instr=0, out_pc=0 in the following cycle.
  - Reset has priority over redirect, push and pop. Reset asserted mid-stream discards all buffered entries.
- imem_addr is combinational from pc. Fetch latency is 0 cycles: imem_instr is sampled in the same cycle imem_addr is driven.
- pop = out_valid & out_ready.
- push = ~redirect_valid & ((count < FIFO_DEPTH) | pop).
  - Push is allowed into a full FIFO when a pop happens in the same cycle. Count stays unchanged and the entry order is preserved.
- On push:
  - Entry written with {pc, imem_instr}.
  - pc <= pc + 32'd4. Wraps modulo 2^32; imem_addr wraps modulo IMEM_SIZE through truncation.
- No push and no redirect: pc holds. No memory side effects; re-reading the same address is harmless.
- Redirect (redirect_valid==1, reset==1):
  - FIFO flushed: count and both pointers <= 0, so out_valid=0 next cycle.
  - pc <= {redirect_pc[31:2], 2'b00}; a misaligned target is silently aligned.
  - No push that cycle.
  - A pop in the same cycle is still reported to decode as accepted; flush overrides its effect on count.
  - The first target instruction appears at out_* in the second cycle after redirect: cycle R+1 pushes, cycle R+2 shows out_valid=1.
- Back-to-back redirects: each one restarts the sequence; the last one wins.
- out_instr and out_pc are driven from the head entry and stay stable while out_valid & ~out_ready (standard hold rule).
- Sustained throughput is 1 instruction per cycle while out_ready=1.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - Extra output port fetch_count, 32 bits, counting accepted pops.
  - Extra output port stall_count, 32 bits, counting cycles with count==FIFO_DEPTH & ~pop.
  - Both reset to 0, increment by 1, and wrap at 2^32.
  - Redirect does not clear them.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Defines.v (shared): INSTRMEM_SIZE, RESET_PC default, and the NOP encoding used by decode.
- Guard the file with the usual `ifndef include guard.
- Sub-module fetch_fifo:
  - Parameterised width (64) and depth.
  - Ports: push, pop, flush, din, dout, empty, full, count.
  - Instantiated once.
- PC logic and push/redirect arbitration remain in fetch_unit.

Test Plan:
- Reset release, memory preloaded with mem[i]=32'h1000_0000+i, out_ready=1:
  - Cycle 1 after release: out_valid=1, out_pc=0, out_instr=32'h1000_0000.
  - Following cycles: out_pc steps 4, 8, 12 with matching instr, one per cycle.
- out_ready=0 for 5 cycles after the first fetch:
  - FIFO fills to 2 and pc holds at 8.
  - out_pc=0 stable throughout.
  - After out_ready=1, the sequence 0, 4, 8 continues with no gaps or duplicates.
- Redirect to 32'h0000_0043 while the FIFO holds 2 entries:
  - Next cycle out_valid=0.
  - The cycle after: out_pc=32'h40, out_instr=mem[16].
- Redirect on consecutive cycles to 0x20 then 0x80:
  - Only 0x80 and its successors emerge; no 0x20 entry.
- PC wrap:
  - RESET_PC=32'hFFFF_FFF8 with IMEM_SIZE=256 yields out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - imem_addr runs 254, 255, 0.
- reset asserted mid-stream with FIFO full and redirect_valid=1:
  - Next cycle out_valid=0 and pc=RESET_PC; the redirect is ignored.
  - With FETCH_PERF_EN: fetch_count=0, and stall_count increments once per full-stall cycle.
